// File: rtl/spi_cmd_pkg.sv
// Shared opcodes, error bit positions, FSM states and draw-entry sizing for
// the SPI command decoder.
package spi_cmd_pkg;

    localparam logic [7:0] OP_LOAD   = 8'h01;
    localparam logic [7:0] OP_DRAW   = 8'h02;
    localparam logic [7:0] OP_CLEAR  = 8'h03;
    localparam logic [7:0] TERM_BYTE = 8'h00;

    localparam int ERR_OPCODE = 0;
    localparam int ERR_TERM   = 1;
    localparam int ERR_ABORT  = 2;
    localparam int ERR_OVF    = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_ID,
        ST_LD_DATA,
        ST_DR_ARGS,
        ST_TERM,
        ST_DISCARD
    } state_t;

    // Draw entry layout, MSB first: {clear, id, x, y, scale}
    function automatic int draw_entry_w(input int id_w, input int coord_w, input int scale_w);
        return 1 + id_w + 2 * coord_w + scale_w;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous first-word fall-through FIFO for queued draw/clear commands.
// A push while full is taken when a pop happens in the same cycle.
module cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             sys_clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge sys_clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge sys_clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/spi_cmd_decoder.sv
// Parses SPI frame bytes into sprite-memory writes and queued draw/clear
// commands, with sticky error flags and a good-packet counter.
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter int ID_W         = 8,
    parameter int SPRITE_BYTES = 512,
    parameter int COORD_W      = 11,
    parameter int SCALE_W      = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            sys_clock,
    input  logic                            reset_n,
    input  logic                            frame_active,
    input  logic                            byte_valid,
    input  logic [7:0]                      byte_data,
    output logic                            sprite_we,
    output logic [ID_W-1:0]                 sprite_id,
    output logic [$clog2(SPRITE_BYTES)-1:0] sprite_addr,
    output logic [7:0]                      sprite_data,
    output logic                            draw_valid,
    input  logic                            draw_ready,
    output logic                            draw_clear,
    output logic [ID_W-1:0]                 draw_id,
    output logic [COORD_W-1:0]              draw_x,
    output logic [COORD_W-1:0]              draw_y,
    output logic [SCALE_W-1:0]              draw_scale,
    output logic [3:0]                      err_flags,
    input  logic                            err_clear,
    output logic [15:0]                     pkt_count
);
    localparam int AW = $clog2(SPRITE_BYTES);
    localparam int EW = draw_entry_w(ID_W, COORD_W, SCALE_W);

    state_t        state;
    logic [AW-1:0] addr;
    logic [2:0]    arg_cnt;
    logic [47:0]   args;
    logic [7:0]    op_q;
    logic          push_q;
    logic [EW-1:0] push_entry;
    logic [EW-1:0] head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          ovf;
    logic          push_ok;

    // The queue decision is made in the push cycle so a simultaneous pop frees the slot.
    assign draw_valid = !fifo_empty;
    assign pop        = draw_valid && draw_ready;
    assign ovf        = push_q && fifo_full && !pop;
    assign push_ok    = push_q && !ovf;

    assign {draw_clear, draw_id, draw_x, draw_y, draw_scale} = draw_valid ? head : '0;

    cmd_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clock (sys_clock),
        .reset_n   (reset_n),
        .push      (push_q),
        .din       (push_entry),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .dout      (head)
    );

    always_ff @(posedge sys_clock) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            addr        <= '0;
            arg_cnt     <= '0;
            args        <= '0;
            op_q        <= '0;
            push_q      <= 1'b0;
            push_entry  <= '0;
            sprite_we   <= 1'b0;
            sprite_id   <= '0;
            sprite_addr <= '0;
            sprite_data <= '0;
            err_flags   <= '0;
            pkt_count   <= '0;
        end else begin
            sprite_we <= 1'b0;
            push_q    <= 1'b0;
            err_flags <= err_clear ? 4'b0 : err_flags;
            pkt_count <= pkt_count + {15'd0, push_ok};
            if (ovf) err_flags[ERR_OVF] <= 1'b1;

            if (!frame_active) begin
                if (state != ST_IDLE && state != ST_DISCARD) err_flags[ERR_ABORT] <= 1'b1;
                state <= ST_IDLE;
            end else if (byte_valid) begin
                case (state)
                    ST_IDLE: begin
                        op_q <= byte_data;
                        case (byte_data)
                            OP_LOAD:   state <= ST_LD_ID;
                            OP_DRAW: begin
                                state   <= ST_DR_ARGS;
                                arg_cnt <= '0;
                            end
                            OP_CLEAR:  state <= ST_TERM;
                            TERM_BYTE: state <= ST_IDLE;
                            default: begin
                                err_flags[ERR_OPCODE] <= 1'b1;
                                state <= ST_DISCARD;
                            end
                        endcase
                    end
                    ST_LD_ID: begin
                        sprite_id <= ID_W'(byte_data);
                        addr      <= '0;
                        state     <= ST_LD_DATA;
                    end
                    ST_LD_DATA: begin
                        sprite_we   <= 1'b1;
                        sprite_addr <= addr;
                        sprite_data <= byte_data;
                        addr        <= addr + 1'b1;
                        if (addr == AW'(SPRITE_BYTES - 1)) state <= ST_TERM;
                    end
                    ST_DR_ARGS: begin
                        args    <= {args[39:0], byte_data};
                        arg_cnt <= arg_cnt + 3'd1;
                        if (arg_cnt == 3'd5) state <= ST_TERM;
                    end
                    ST_TERM: begin
                        if (byte_data == TERM_BYTE) begin
                            state <= ST_IDLE;
                            if (op_q == OP_LOAD) begin
                                pkt_count <= pkt_count + {15'd0, push_ok} + 16'd1;
                            end else begin
                                push_q <= 1'b1;
                                if (op_q == OP_DRAW)
                                    push_entry <= {1'b0, ID_W'(args[47:40]), COORD_W'(args[39:24]),
                                                   COORD_W'(args[23:8]), SCALE_W'(args[7:0])};
                                else
                                    push_entry <= {1'b1, {(EW-1){1'b0}}};
                            end
                        end else begin
                            err_flags[ERR_TERM] <= 1'b1;
                            state <= ST_DISCARD;
                        end
                    end
                    ST_DISCARD: state <= ST_DISCARD;
                    default:    state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: scoreboard queues for sprite writes and
// queued draw/clear entries, plus direct checks of flags and counters.
module tb_spi_cmd_decoder;

    logic        sys_clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_active = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        draw_ready = 1'b0;
    logic        err_clear = 1'b0;
    logic        sprite_we;
    logic [7:0]  sprite_id;
    logic [8:0]  sprite_addr;
    logic [7:0]  sprite_data;
    logic        draw_valid;
    logic        draw_clear;
    logic [7:0]  draw_id;
    logic [10:0] draw_x;
    logic [10:0] draw_y;
    logic [7:0]  draw_scale;
    logic [3:0]  err_flags;
    logic [15:0] pkt_count;

    int checks = 0;
    int errors = 0;
    int wr_seen = 0;
    int exp_pkt = 0;

    logic [24:0] wq[$];   // {id, addr, data}
    logic [38:0] dq[$];   // {clear, id, x, y, scale}

    spi_cmd_decoder #(
        .ID_W(8), .SPRITE_BYTES(512), .COORD_W(11), .SCALE_W(8), .FIFO_DEPTH(4)
    ) dut (
        .sys_clock(sys_clock), .reset_n(reset_n), .frame_active(frame_active),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .sprite_we(sprite_we), .sprite_id(sprite_id), .sprite_addr(sprite_addr),
        .sprite_data(sprite_data), .draw_valid(draw_valid), .draw_ready(draw_ready),
        .draw_clear(draw_clear), .draw_id(draw_id), .draw_x(draw_x), .draw_y(draw_y),
        .draw_scale(draw_scale), .err_flags(err_flags), .err_clear(err_clear),
        .pkt_count(pkt_count)
    );

    always #5 sys_clock = ~sys_clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sprite-write scoreboard
    always @(negedge sys_clock) begin
        if (reset_n && sprite_we) begin
            wr_seen++;
            if (wq.size() == 0) check("spr_extra", 1, 0);
            else check("spr_write", {sprite_id, sprite_addr, sprite_data}, wq.pop_front());
        end
    end

    // Draw-queue scoreboard: compare the head whenever it will be popped
    always @(negedge sys_clock) begin
        if (reset_n && draw_valid && draw_ready) begin
            if (dq.size() == 0) check("draw_extra", 1, 0);
            else check("draw_head", {draw_clear, draw_id, draw_x, draw_y, draw_scale}, dq.pop_front());
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clock); #1;
            byte_valid = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge sys_clock); #1;
        byte_valid = 1'b1;
        byte_data  = b;
    endtask

    task automatic frame_start();
        @(posedge sys_clock); #1;
        byte_valid   = 1'b0;
        frame_active = 1'b1;
    endtask

    task automatic frame_end();
        @(posedge sys_clock); #1;
        byte_valid   = 1'b0;
        frame_active = 1'b0;
        tick(3);
    endtask

    task automatic send_draw(input logic [7:0] id, input logic [15:0] x, input logic [15:0] y,
                             input logic [7:0] sc, input logic [7:0] term);
        send(8'h02); send(id); send(x[15:8]); send(x[7:0]);
        send(y[15:8]); send(y[7:0]); send(sc); send(term);
    endtask

    task automatic clear_errs();
        @(posedge sys_clock); #1;
        err_clear = 1'b1;
        @(posedge sys_clock); #1;
        err_clear = 1'b0;
    endtask

    task automatic drain();
        int n;
        draw_ready = 1'b1;
        n = 0;
        while (draw_valid && n < 50) begin
            @(posedge sys_clock); #1;
            n++;
        end
        draw_ready = 1'b0;
        check("drain_valid", draw_valid, 0);
        check("drain_sb", dq.size(), 0);
    endtask

    function automatic logic [38:0] dr_ent(input logic [7:0] id, input logic [15:0] x,
                                           input logic [15:0] y, input logic [7:0] sc);
        return {1'b0, id, x[10:0], y[10:0], sc};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        reset_n = 1'b1;
        tick(1);
        check("rst_we", sprite_we, 0);
        check("rst_valid", draw_valid, 0);
        check("rst_err", err_flags, 0);
        check("rst_pkt", pkt_count, 0);
        check("rst_fields", {draw_clear, draw_id, draw_x, draw_y, draw_scale}, 0);

        // LOAD id=2 with 512 payload bytes, back to back
        frame_start();
        send(8'h01); send(8'h02);
        for (int i = 0; i < 512; i++) begin
            wq.push_back({8'd2, 9'(i), 8'(i)});
            send(8'(i));
        end
        send(8'h00);
        exp_pkt = 1;
        frame_end();
        check("load_writes", wr_seen, 512);
        check("load_sb", wq.size(), 0);
        check("load_pkt", pkt_count, exp_pkt);
        check("load_err", err_flags, 0);

        // Two DRAWs held at the head with draw_ready low
        frame_start();
        send_draw(8'd2, 16'h0008, 16'h121A, 8'd2, 8'h00);
        send_draw(8'd2, 16'h0008, 16'h121A, 8'd2, 8'h00);
        dq.push_back(dr_ent(8'd2, 16'h0008, 16'h121A, 8'd2));
        dq.push_back(dr_ent(8'd2, 16'h0008, 16'h121A, 8'd2));
        exp_pkt += 2;
        frame_end();
        check("draw_valid", draw_valid, 1);
        check("draw_stall", {draw_clear, draw_id, draw_x, draw_y, draw_scale},
              dr_ent(8'd2, 16'h0008, 16'h121A, 8'd2));
        tick(4);
        check("draw_stable_y", draw_y, 11'h21A);
        check("draw_pkt", pkt_count, exp_pkt);
        drain();

        // Byte with CS low is ignored
        send(8'h7F);
        tick(2);
        check("cs_low_err", err_flags, 0);

        // Unknown opcode discards the rest of the frame
        frame_start();
        send(8'h7F); send(8'h01); send(8'h02); send(8'h00); send(8'h03); send(8'h00);
        frame_end();
        check("opc_err", err_flags, 4'b0001);
        check("opc_valid", draw_valid, 0);
        check("opc_pkt", pkt_count, exp_pkt);
        check("opc_writes", wr_seen, 512);
        clear_errs();
        tick(1);
        check("errclr", err_flags, 0);

        // Bad terminator
        frame_start();
        send_draw(8'd5, 16'h0001, 16'h0002, 8'd3, 8'h55);
        frame_end();
        check("term_err", err_flags, 4'b0010);
        check("term_valid", draw_valid, 0);
        check("term_pkt", pkt_count, exp_pkt);
        clear_errs();

        // Frame abort after the third DRAW argument, then CLEAR in the next frame
        frame_start();
        send(8'h02); send(8'd5); send(8'h00); send(8'h01);
        frame_end();
        check("abort_err", err_flags, 4'b0100);
        clear_errs();
        frame_start();
        send(8'h03); send(8'h00);
        dq.push_back({1'b1, 38'd0});
        exp_pkt += 1;
        frame_end();
        check("clear_valid", draw_valid, 1);
        check("clear_flag", draw_clear, 1);
        check("clear_pkt", pkt_count, exp_pkt);
        drain();
        check("abort_noerr", err_flags, 0);

        // Overflow: five DRAWs into a depth-4 queue, fifth dropped
        frame_start();
        for (int i = 0; i < 5; i++) begin
            send_draw(8'(10 + i), 16'(100 + i), 16'(200 + i), 8'(i), 8'h00);
            if (i < 4) dq.push_back(dr_ent(8'(10 + i), 16'(100 + i), 16'(200 + i), 8'(i)));
        end
        exp_pkt += 4;
        frame_end();
        check("ovf_err", err_flags, 4'b1000);
        check("ovf_pkt", pkt_count, exp_pkt);
        check("ovf_head_id", draw_id, 10);
        drain();
        clear_errs();

        // Fifth commit coincides with a pop and is accepted
        frame_start();
        for (int i = 0; i < 5; i++) begin
            dq.push_back(dr_ent(8'(20 + i), 16'(300 + i), 16'(400 + i), 8'(i + 1)));
            send_draw(8'(20 + i), 16'(300 + i), 16'(400 + i), 8'(i + 1), 8'h00);
        end
        @(posedge sys_clock); #1;
        byte_valid = 1'b0;
        draw_ready = 1'b1;
        @(posedge sys_clock); #1;
        draw_ready = 1'b0;
        exp_pkt += 5;
        frame_end();
        check("popovf_err", err_flags, 0);
        check("popovf_pkt", pkt_count, exp_pkt);
        check("popovf_head_id", draw_id, 21);
        drain();

        check("final_wq", wq.size(), 0);
        check("final_dq", dq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
